// File: rtl/lut_neuron_sweeper.sv
// Sweeps every input code through one LUT neuron, packs PACK results per word
// and streams the packed truth table out over a valid/ready master port.
module lut_neuron_sweeper #(
    parameter int IN_W       = 8,
    parameter int OUT_W      = 2,
    parameter int PACK       = 8,
    parameter int NEURON_LAT = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [IN_W-1:0]       nrn_in,
    input  logic [OUT_W-1:0]      nrn_out,
    output logic [OUT_W*PACK-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last
);
    localparam int CW = $clog2(PACK + 1);
    localparam int TW = (NEURON_LAT > 0) ? NEURON_LAT : 1;
    localparam logic [IN_W:0]   LAST_ADDR = (IN_W + 1)'((1 << IN_W) - 1);
    localparam logic [IN_W:0]   CNT_ONE   = (IN_W + 1)'(1);
    localparam logic [IN_W-1:0] ADDR_ONE  = IN_W'(1);
    localparam logic [CW-1:0]   PACK_FULL = CW'(PACK);
    localparam logic [CW-1:0]   CNT1      = CW'(1);

    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic                    busy_q, busy_d, done_q, done_d;
    logic [IN_W-1:0]         nrn_in_q, nrn_in_d;
    logic [IN_W:0]           cnt_q, cnt_d;
    logic [CW-1:0]           pack_cnt_q, pack_cnt_d;
    logic [OUT_W*PACK-1:0]   pack_q, pack_d;
    logic [OUT_W*PACK-1:0]   m_data_q, m_data_d;
    logic                    m_valid_q, m_valid_d, m_last_q, m_last_d;
    logic [TW-1:0]           tag_q, tag_d;

    logic          handshake, xfer, issue, capture;
    logic [CW-1:0] avail;
    int            inflight;

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        nrn_in_d   = nrn_in_q;
        cnt_d      = cnt_q;
        pack_cnt_d = pack_cnt_q;
        pack_d     = pack_q;
        m_data_d   = m_data_q;
        m_valid_d  = m_valid_q;
        m_last_d   = m_last_q;
        tag_d      = '0;

        handshake = m_valid_q & m_ready;
        xfer      = (pack_cnt_q == PACK_FULL) && (!m_valid_q || m_ready);
        // A word leaving the pack register frees all its entries this same edge.
        avail     = xfer ? '0 : pack_cnt_q;
        inflight  = 0;
        for (int i = 0; i < TW; i++) begin
            inflight += int'(tag_q[i]);
        end
        issue = (state_q == S_SWEEP) && (int'(avail) + inflight < PACK);

        if (NEURON_LAT > 0) begin
            tag_d   = (tag_q << 1) | TW'(issue);
            capture = tag_q[TW-1];
        end else begin
            capture = issue;
        end

        if (handshake) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end
        if (xfer) begin
            m_data_d   = pack_q;
            m_valid_d  = 1'b1;
            m_last_d   = (state_q == S_DRAIN);
            pack_cnt_d = '0;
        end
        if (capture) begin
            pack_d[avail*OUT_W +: OUT_W] = nrn_out;
            pack_cnt_d = avail + CNT1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_SWEEP;
                    busy_d     = 1'b1;
                    nrn_in_d   = '0;
                    cnt_d      = '0;
                    pack_cnt_d = '0;
                    tag_d      = '0;
                end
            end
            S_SWEEP: begin
                if (issue) begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == LAST_ADDR) begin
                        state_d = S_DRAIN;
                    end else begin
                        nrn_in_d = nrn_in_q + ADDR_ONE;
                    end
                end
            end
            S_DRAIN: begin
                if (handshake && m_last_q) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            nrn_in_q   <= '0;
            cnt_q      <= '0;
            pack_cnt_q <= '0;
            pack_q     <= '0;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            tag_q      <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            nrn_in_q   <= nrn_in_d;
            cnt_q      <= cnt_d;
            pack_cnt_q <= pack_cnt_d;
            pack_q     <= pack_d;
            m_data_q   <= m_data_d;
            m_valid_q  <= m_valid_d;
            m_last_q   <= m_last_d;
            tag_q      <= tag_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign nrn_in  = nrn_in_q;
    assign m_data  = m_data_q;
    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;
endmodule

// File: tb/tb_lut_neuron_sweeper.sv
// Randomized bench for lut_neuron_sweeper: a combinational and a 2-cycle
// neuron are swept and every word is compared against a truth-table model.
module tb_lut_neuron_sweeper;
    localparam int IN_W  = 8;
    localparam int OUT_W = 2;
    localparam int PACK  = 8;
    localparam int N     = 1 << IN_W;
    localparam int WORDS = N / PACK;
    localparam int DW    = OUT_W * PACK;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start0 = 1'b0, start2 = 1'b0, m_ready = 1'b0;
    always #5 clk = ~clk;

    logic            busy0, done0, m_valid0, m_last0;
    logic [IN_W-1:0] nrn_in0;
    logic [OUT_W-1:0] nrn_out0;
    logic [DW-1:0]   m_data0;
    logic            busy2, done2, m_valid2, m_last2;
    logic [IN_W-1:0] nrn_in2;
    logic [OUT_W-1:0] nrn_out2, pipe1, pipe2;
    logic [DW-1:0]   m_data2;

    int         mode = 0;
    int         sel = 0;
    logic [1:0] lut [N];

    lut_neuron_sweeper #(.IN_W(IN_W), .OUT_W(OUT_W), .PACK(PACK), .NEURON_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0),
        .nrn_in(nrn_in0), .nrn_out(nrn_out0), .m_data(m_data0), .m_valid(m_valid0),
        .m_ready(m_ready), .m_last(m_last0));

    lut_neuron_sweeper #(.IN_W(IN_W), .OUT_W(OUT_W), .PACK(PACK), .NEURON_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
        .nrn_in(nrn_in2), .nrn_out(nrn_out2), .m_data(m_data2), .m_valid(m_valid2),
        .m_ready(m_ready), .m_last(m_last2));

    // Neurons under test: combinational, and a 2-stage registered version.
    assign nrn_out0 = (mode == 0) ? nrn_in0[1:0] : (mode == 1) ? nrn_in0[7:6] : lut[nrn_in0];
    always @(posedge clk) begin
        pipe1 <= (mode == 0) ? nrn_in2[1:0] : (mode == 1) ? nrn_in2[7:6] : lut[nrn_in2];
        pipe2 <= pipe1;
    end
    assign nrn_out2 = pipe2;

    logic            mv, ml, bz, dn;
    logic [DW-1:0]   md;
    logic [IN_W-1:0] ni;
    assign mv = (sel != 0) ? m_valid2 : m_valid0;
    assign ml = (sel != 0) ? m_last2  : m_last0;
    assign bz = (sel != 0) ? busy2    : busy0;
    assign dn = (sel != 0) ? done2    : done0;
    assign md = (sel != 0) ? m_data2  : m_data0;
    assign ni = (sel != 0) ? nrn_in2  : nrn_in0;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] ref_f(input int a);
        case (mode)
            0:       return 2'(a % 4);
            1:       return 2'(a / 64);
            default: return lut[a];
        endcase
    endfunction

    logic [DW-1:0] exp_words [WORDS];

    task automatic build_expected();
        for (int w = 0; w < WORDS; w++) begin
            logic [DW-1:0] word;
            word = '0;
            for (int k = 0; k < PACK; k++) begin
                word[k*OUT_W +: OUT_W] = ref_f(w * PACK + k);
            end
            exp_words[w] = word;
        end
    endtask

    task automatic set_start(input logic v);
        if (sel != 0) start2 = v;
        else          start0 = v;
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_rst_busy"},  32'(bz), 32'd0);
        chk({name, "_rst_done"},  32'(dn), 32'd0);
        chk({name, "_rst_valid"}, 32'(mv), 32'd0);
        chk({name, "_rst_last"},  32'(ml), 32'd0);
        chk({name, "_rst_data"},  32'(md), 32'd0);
        chk({name, "_rst_nrnin"}, 32'(ni), 32'd0);
    endtask

    task automatic run_sweep(input string name, input int s, input int ready_pct,
                             input int restart_at, input int abort_at, input int exp_cycles);
        int   got, done_cyc;
        logic prev_v, prev_r, prev_l, done_pending, finished;
        logic [DW-1:0] prev_d;
        sel = s;
        build_expected();
        got = 0; done_cyc = -1;
        prev_v = 1'b0; prev_r = 1'b0; prev_l = 1'b0; prev_d = '0;
        done_pending = 1'b0; finished = 1'b0;
        @(negedge clk);
        set_start(1'b1);
        m_ready = ($urandom_range(99) < 32'(ready_pct));
        for (int cyc = 1; cyc <= 3000 && !finished; cyc++) begin
            @(negedge clk);
            set_start(1'b0);
            if (cyc == 1) begin
                chk({name, "_busy_after_start"}, 32'(bz), 32'd1);
                chk({name, "_nrnin_after_start"}, 32'(ni), 32'd0);
            end
            if (prev_v && !prev_r) begin
                chk({name, "_hold_valid"}, 32'(mv), 32'd1);
                chk({name, "_hold_data"}, 32'(md), 32'(prev_d));
                chk({name, "_hold_last"}, 32'(ml), 32'(prev_l));
            end
            if (done_cyc >= 0) begin
                chk({name, "_done_one_cycle"}, 32'(dn), 32'd0);
                chk({name, "_busy_idle"}, 32'(bz), 32'd0);
                finished = 1'b1;
            end else begin
                chk({name, "_done"}, 32'(dn), 32'(done_pending));
                if (dn) begin
                    done_cyc = cyc;
                    chk({name, "_busy_with_done"}, 32'(bz), 32'd0);
                    if (exp_cycles > 0) chk({name, "_cycles"}, 32'(cyc), 32'(exp_cycles));
                end
            end
            done_pending = 1'b0;
            if (abort_at >= 0 && got == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs({name, "_async"});
                @(negedge clk);
                @(negedge clk);
                check_reset_outputs(name);
                rst_n = 1'b1;
                m_ready = 1'b0;
                $display("%s: reset applied after %0d words", name, got);
                return;
            end
            if (got == restart_at && restart_at >= 0) set_start(1'b1);
            m_ready = ($urandom_range(99) < 32'(ready_pct));
            if (mv && m_ready && !finished) begin
                if (got < WORDS) begin
                    chk({name, "_data"}, 32'(md), 32'(exp_words[got]));
                    chk({name, "_last"}, 32'(ml), 32'(got == WORDS - 1));
                end else begin
                    chk({name, "_extra_word"}, 32'(got), 32'(WORDS - 1));
                end
                $display("%s word %0d data=%h last=%0b", name, got, md, ml);
                if (ml) done_pending = 1'b1;
                got++;
            end
            prev_v = mv; prev_r = m_ready; prev_d = md; prev_l = ml;
        end
        chk({name, "_word_count"}, 32'(got), 32'(WORDS));
        if (!finished) chk({name, "_timeout"}, 32'd1, 32'd0);
        m_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) lut[i] = 2'($urandom_range(3));
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        mode = 0;
        run_sweep("t1", 0, 100, -1, -1, N + 3);
        chk("t1_nrnin_hold", 32'(ni), 32'(N - 1));

        mode = 1;
        run_sweep("t2", 0, 100, -1, -1, N + 3);

        mode = 0;
        run_sweep("t3", 0, 50, -1, -1, 0);

        mode = 1;
        run_sweep("t4", 1, 100, -1, -1, 0);
        mode = 2;
        run_sweep("t4r", 1, 60, -1, -1, 0);

        mode = 2;
        run_sweep("t5", 0, 80, 10, -1, 0);

        mode = 1;
        run_sweep("t6a", 0, 70, -1, 12, 0);
        @(negedge clk);
        run_sweep("t6b", 0, 70, -1, -1, 0);
        run_sweep("t6c", 1, 100, -1, 5, 0);
        @(negedge clk);
        run_sweep("t6d", 1, 50, -1, -1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
